wdt_window: RTL and testbench

//  Parametrised windowed watchdog for the f8 system: prescaled down-counter, keyed kick,

---
 rtl/wdt_window.sv | 191 +++++++++++++++++++
 tb/tb_wdt_window.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wdt_window.sv
// ---------------------------------------------------------------------------
// wdt_window -- windowed watchdog for the f8 system.
//
// A prescaled down-counter that must be kicked with a key before it reaches
// zero. An optional window rejects kicks that arrive too early. A lock bit
// freezes the configuration registers. A CPU trap, a timeout, a bad key or an
// early kick each raise a sys_reset pulse of PULSE_LEN cycles. Sticky cause
// flags record which event produced the most recent pulse.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      power-on reset, synchronous, active-high
//   trap       in   1      CPU illegal-op trap, converted to a watchdog reset
//   reg_wr     in   1      register write strobe, one cycle per write
//   reg_addr   in   2      0=CTRL 1=RELOAD 2=WINDOW 3=KICK
//   reg_wdata  in   CNT_W  write data
//   ctrl_out   out  8      {POR,0,KEYERR,TRAP,TIMEOUT,LOCK,WIN_EN,EN}
//   count_out  out  CNT_W  current counter value
//   sys_reset  out  1      reset | (state == PULSE)
// ---------------------------------------------------------------------------
module wdt_window #(
    parameter int          CNT_W     = 16,
    parameter int          PRESC_W   = 4,
    parameter int          PULSE_LEN = 8,
    parameter logic [7:0]  KEY       = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trap,
    input  logic             reg_wr,
    input  logic [1:0]       reg_addr,
    input  logic [CNT_W-1:0] reg_wdata,
    output logic [7:0]       ctrl_out,
    output logic [CNT_W-1:0] count_out,
    output logic             sys_reset
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RELOAD = 2'd1;
    localparam logic [1:0] ADDR_WINDOW = 2'd2;

    // Wide enough to hold PULSE_LEN-1 even when PULSE_LEN is 1.
    localparam int PC_W = $clog2(PULSE_LEN + 1);

    logic [1:0]         state_q,     state_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [CNT_W-1:0]   reload_q,    reload_d;
    logic [CNT_W-1:0]   window_q,    window_d;
    logic [PRESC_W-1:0] presc_q,     presc_d;
    logic [PC_W-1:0]    pulse_cnt_q, pulse_cnt_d;
    logic               en_q,        en_d;
    logic               win_en_q,    win_en_d;
    logic               lock_q,      lock_d;
    logic               f_timeout_q, f_timeout_d;
    logic               f_trap_q,    f_trap_d;
    logic               f_keyerr_q,  f_keyerr_d;
    logic               f_por_q,     f_por_d;

    logic tick;
    logic kick_wr;
    logic ev_trap;
    logic ev_keyerr;
    logic ev_timeout;

    // Event decode. Kicks are only meaningful while running; trap is ignored
    // while a pulse is already in progress so the pulse cannot be stretched.
    always_comb begin
        tick       = (state_q == ST_RUN) && (presc_q == '1);
        kick_wr    = reg_wr && (reg_addr == 2'd3) && (state_q == ST_RUN);
        ev_trap    = trap && (state_q != ST_PULSE);
        ev_keyerr  = kick_wr && ((reg_wdata[7:0] != KEY) ||
                                 (win_en_q && (count_q > window_q)));
        ev_timeout = tick && (count_q == '0);
    end

    // NOTE: every *_d gets a default from its *_q first, so no branch below
    // can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        window_d    = window_q;
        presc_d     = presc_q;
        pulse_cnt_d = pulse_cnt_q;
        en_d        = en_q;
        win_en_d    = win_en_q;
        lock_d      = lock_q;
        f_timeout_d = f_timeout_q;
        f_trap_d    = f_trap_q;
        f_keyerr_d  = f_keyerr_q;
        f_por_d     = f_por_q;

        if (state_q == ST_PULSE) begin
            // Writes and trap are ignored here; only the pulse timer advances.
            if (pulse_cnt_q == PC_W'(PULSE_LEN - 1)) begin
                state_d  = ST_IDLE;
                en_d     = 1'b0;
                win_en_d = 1'b0;
                lock_d   = 1'b0;
                count_d  = reload_q;
            end else begin
                pulse_cnt_d = pulse_cnt_q + PC_W'(1);
            end
        end else begin
            if (state_q == ST_RUN) begin
                presc_d = presc_q + PRESC_W'(1);
                if (tick && (count_q != '0)) begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            if (ev_trap || ev_keyerr || ev_timeout) begin
                // Priority trap > keyerr > timeout decides which cause sticks.
                state_d     = ST_PULSE;
                pulse_cnt_d = '0;
                presc_d     = '0;
                count_d     = count_q;
                lock_d      = 1'b0;
                f_por_d     = 1'b0;
                f_trap_d    = ev_trap;
                f_keyerr_d  = !ev_trap && ev_keyerr;
                f_timeout_d = !ev_trap && !ev_keyerr;
            end else if (kick_wr) begin
                count_d = reload_q;
                presc_d = '0;
            end else if (reg_wr && !lock_q) begin
                case (reg_addr)
                    ADDR_CTRL: begin
                        en_d     = reg_wdata[0];
                        win_en_d = reg_wdata[1];
                        lock_d   = reg_wdata[2];
                        if ((state_q == ST_IDLE) && reg_wdata[0]) begin
                            state_d = ST_RUN;
                            count_d = reload_q;
                            presc_d = '0;
                        end else if ((state_q == ST_RUN) && !reg_wdata[0]) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ADDR_RELOAD: reload_d = reg_wdata;
                    ADDR_WINDOW: window_d = reg_wdata;
                    default: ; // KICK outside RUN is ignored
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '1;
            reload_q    <= '1;
            window_q    <= '1;
            presc_q     <= '0;
            pulse_cnt_q <= '0;
            en_q        <= 1'b0;
            win_en_q    <= 1'b0;
            lock_q      <= 1'b0;
            f_timeout_q <= 1'b0;
            f_trap_q    <= 1'b0;
            f_keyerr_q  <= 1'b0;
            f_por_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            window_q    <= window_d;
            presc_q     <= presc_d;
            pulse_cnt_q <= pulse_cnt_d;
            en_q        <= en_d;
            win_en_q    <= win_en_d;
            lock_q      <= lock_d;
            f_timeout_q <= f_timeout_d;
            f_trap_q    <= f_trap_d;
            f_keyerr_q  <= f_keyerr_d;
            f_por_q     <= f_por_d;
        end
    end

    assign ctrl_out  = {f_por_q, 1'b0, f_keyerr_q, f_trap_q, f_timeout_q,
                        lock_q, win_en_q, en_q};
    assign count_out = count_q;
    assign sys_reset = reset | (state_q == ST_PULSE);

endmodule

// File: tb/tb_wdt_window.sv
// ---------------------------------------------------------------------------
// tb_wdt_window -- directed bench for wdt_window (default parameters).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_wdt_window;

    logic        clk = 1'b0;
    logic        reset;
    logic        trap;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [7:0]  ctrl_out;
    logic [15:0] count_out;
    logic        sys_reset;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitors for the long kick run.
    int   min_count;
    logic rst_seen;

    wdt_window dut (
        .clk       (clk),
        .reset     (reset),
        .trap      (trap),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .ctrl_out  (ctrl_out),
        .count_out (count_out),
        .sys_reset (sys_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; tracks minimum count and any sys_reset for the kick run.
    task automatic step();
        @(negedge clk);
        if (int'(count_out) < min_count) min_count = int'(count_out);
        if (sys_reset) rst_seen = 1'b1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Register write: takes effect at the next rising edge, returns after it.
    task automatic wr(input logic [1:0] addr, input logic [15:0] data);
        reg_wr    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        step();
        reg_wr    = 1'b0;
        reg_wdata = '0;
    endtask

    initial begin
        reset     = 1'b1;
        trap      = 1'b0;
        reg_wr    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        min_count = 32'h7fff_ffff;
        rst_seen  = 1'b0;

        // 1. Reset state.
        steps(3);
        check("rst_sys_reset", 32'(sys_reset), 32'd1);
        check("rst_ctrl",      32'(ctrl_out),  32'h80);
        check("rst_count",     32'(count_out), 32'hFFFF);
        reset = 1'b0;
        step();
        check("rel_sys_reset", 32'(sys_reset), 32'd0);

        // 2. RELOAD=3, enable, let it time out.
        wr(2'd1, 16'd3);
        wr(2'd0, 16'h0001);
        check("to_cnt3", 32'(count_out), 32'd3);
        steps(16);
        check("to_cnt2", 32'(count_out), 32'd2);
        steps(16);
        check("to_cnt1", 32'(count_out), 32'd1);
        steps(16);
        check("to_cnt0", 32'(count_out), 32'd0);
        steps(15);
        check("to_pre_edge", 32'(sys_reset), 32'd0);
        step();
        check("to_pulse_start", 32'(sys_reset), 32'd1);
        steps(7);
        check("to_pulse_last", 32'(sys_reset), 32'd1);
        step();
        check("to_pulse_end", 32'(sys_reset), 32'd0);
        check("to_ctrl",      32'(ctrl_out),  32'h08);
        check("to_count",     32'(count_out), 32'd3);

        // RELOAD=0: first tick times out; a valid kick on that tick loses.
        wr(2'd1, 16'd0);
        wr(2'd0, 16'h0001);
        steps(15);
        check("r0_no_rst_yet", 32'(sys_reset), 32'd0);
        wr(2'd3, 16'h00A5);
        check("r0_timeout", 32'(sys_reset), 32'd1);
        steps(8);
        check("r0_ctrl", 32'(ctrl_out), 32'h08);

        // 3. RELOAD=100, kicks every 50 cycles for 2000 cycles.
        wr(2'd1, 16'd100);
        wr(2'd0, 16'h0001);
        min_count = 32'h7fff_ffff;
        rst_seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            steps(49);
            wr(2'd3, 16'h00A5);
        end
        check("kick_no_reset", 32'(rst_seen), 32'd0);
        check("kick_min_ge96", 32'(min_count >= 96), 32'd1);
        check("kick_min_97",   32'(min_count), 32'd97);

        // 4. Bad key, then trap (with a second trap mid-pulse).
        check("bk_pre", 32'(sys_reset), 32'd0);
        wr(2'd3, 16'h005A);
        check("bk_rise", 32'(sys_reset), 32'd1);
        steps(8);
        check("bk_end",  32'(sys_reset), 32'd0);
        check("bk_ctrl", 32'(ctrl_out),  32'h20);
        trap = 1'b1;
        step();
        trap = 1'b0;
        check("trap_rise", 32'(sys_reset), 32'd1);
        steps(3);
        trap = 1'b1;
        step();
        trap = 1'b0;
        steps(3);
        check("trap_last", 32'(sys_reset), 32'd1);
        step();
        check("trap_no_extend", 32'(sys_reset), 32'd0);
        check("trap_ctrl",      32'(ctrl_out),  32'h10);

        // 5. Window: early kick at count 15, valid kick at count 8.
        wr(2'd2, 16'd10);
        wr(2'd1, 16'd20);
        wr(2'd0, 16'h0003);
        steps(80);
        check("win_cnt15", 32'(count_out), 32'd15);
        wr(2'd3, 16'h00A5);
        check("win_early_rst", 32'(sys_reset), 32'd1);
        steps(8);
        check("win_early_ctrl", 32'(ctrl_out), 32'h20);
        wr(2'd0, 16'h0003);
        steps(192);
        check("win_cnt8", 32'(count_out), 32'd8);
        wr(2'd3, 16'h00A5);
        check("win_ok_rst",    32'(sys_reset), 32'd0);
        check("win_ok_reload", 32'(count_out), 32'd20);
        check("win_ok_ctrl",   32'(ctrl_out),  32'h23);

        // 6. Lock: CTRL and RELOAD writes ignored, kick still works.
        wr(2'd0, 16'h0000);
        check("unlock_idle", 32'(ctrl_out), 32'h20);
        wr(2'd0, 16'h0005);
        check("lock_ctrl", 32'(ctrl_out), 32'h25);
        wr(2'd0, 16'h0000);
        wr(2'd1, 16'd5);
        check("lock_ctrl_kept", 32'(ctrl_out), 32'h25);
        steps(16);
        check("lock_still_run", 32'(count_out), 32'd19);
        wr(2'd3, 16'h00A5);
        check("lock_reload_kept", 32'(count_out), 32'd20);
        trap = 1'b1;
        step();
        trap = 1'b0;
        check("lock_trap_pulse", 32'(sys_reset), 32'd1);
        steps(2);
        reset = 1'b1;
        step();
        check("abort_sys_reset", 32'(sys_reset), 32'd1);
        reset = 1'b0;
        step();
        check("abort_idle",  32'(sys_reset), 32'd0);
        check("abort_ctrl",  32'(ctrl_out),  32'h80);
        check("abort_count", 32'(count_out), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
